// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI write arbiter: channel packets, FSM states, response codes.
package axi_arb_pkg;

  localparam int ID_W   = 9;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  typedef struct packed {
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
  } aw_pkt_t;

  typedef struct packed {
    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
  } w_pkt_t;

  typedef struct packed {
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
  } b_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } arb_state_e;

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int PW = $clog2(N);

  // Scan N candidates starting at ptr; the first hit wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write slave between NUM_M masters,
// one transaction in flight, with internally generated wlast.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  aw_pkt_t [NUM_M-1:0]      s_aw,
  input  logic    [NUM_M-1:0]      s_awvalid,
  output logic    [NUM_M-1:0]      s_awready,
  input  w_pkt_t  [NUM_M-1:0]      s_w,
  input  logic    [NUM_M-1:0]      s_wvalid,
  output logic    [NUM_M-1:0]      s_wready,
  output b_pkt_t  [NUM_M-1:0]      s_b,
  output logic    [NUM_M-1:0]      s_bvalid,
  input  logic    [NUM_M-1:0]      s_bready,
  output aw_pkt_t                  m_aw,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output w_pkt_t                   m_w,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  b_pkt_t                   m_b,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  output logic [$clog2(NUM_M)-1:0] grant,
  output logic                     busy,
  output logic                     err_wlast
);

  localparam int GW = $clog2(NUM_M);

  arb_state_e    state;
  logic [GW-1:0] rr_ptr;
  aw_pkt_t       aw_q;
  logic [3:0]    beat_cnt;

  logic [GW-1:0] win_idx;
  logic          win_found;
  logic          last_beat;
  logic          w_hs;
  logic          b_hs;

  rr_pick #(.N(NUM_M)) u_pick (
    .req   (s_awvalid),
    .ptr   (rr_ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  // Handshake and last-beat decode for the owner.
  always_comb begin
    last_beat = (beat_cnt == aw_q.awlen);
    w_hs      = (state == DATA) && s_wvalid[grant] && m_wready;
    b_hs      = (state == RESP) && m_bvalid && s_bready[grant];
  end

  // Channel routing: only the owner sees ready/valid, everyone else sees zeros.
  always_comb begin
    s_awready   = '0;
    s_wready    = '0;
    s_b         = '0;
    s_bvalid    = '0;
    m_aw        = aw_q;
    m_awvalid   = 1'b0;
    m_w.wid     = s_w[grant].wid;
    m_w.wdata   = s_w[grant].wdata;
    m_w.wstrb   = s_w[grant].wstrb;
    m_w.wlast   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    err_wlast   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        // AW ready is combinational from the requests, so it is masked
        // while reset is held to keep every handshake output low.
        if (!rst && win_found) begin
          s_awready[win_idx] = 1'b1;
        end
      end
      ADDR: m_awvalid = 1'b1;
      DATA: begin
        m_wvalid        = s_wvalid[grant];
        s_wready[grant] = m_wready;
        m_w.wlast       = last_beat;
        err_wlast       = w_hs && (s_w[grant].wlast != last_beat);
      end
      RESP: begin
        s_bvalid[grant] = m_bvalid;
        s_b[grant]      = m_b;
        m_bready        = s_bready[grant];
      end
      default: ;
    endcase
  end

  // Transaction FSM: capture AW, forward it, count W beats, wait for B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      aw_q     <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            aw_q     <= s_aw[win_idx];
            grant    <= win_idx;
            beat_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (m_awready) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (last_beat) begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            rr_ptr <= (grant == GW'(NUM_M - 1)) ? '0 : grant + GW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
